// File: rtl/draw_scheduler.sv
// draw_scheduler: arbitrates screen/sprite draw requests and streams one pixel per cycle to the VGA path
module draw_scheduler #(
    parameter int SCR_W  = 160,
    parameter int SCR_H  = 120,
    parameter int SPR_W  = 40,
    parameter int SPR_H  = 40,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              screenReq,
    input  logic [4:0]        screenSel,
    input  logic              screenBlack,
    input  logic              spriteReq,
    input  logic [4:0]        spriteSel,
    input  logic [7:0]        spriteX,
    input  logic [6:0]        spriteY,
    output logic              screenAck,
    output logic              spriteAck,
    output logic              screenDone,
    output logic              spriteDone,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [ADDR_W-1:0] romAddr,
    output logic [4:0]        memorySel,
    output logic              black,
    output logic              plot,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;
    localparam logic [7:0] SCR_LAST_COL = 8'(SCR_W - 1);
    localparam logic [7:0] SPR_LAST_COL = 8'(SPR_W - 1);
    localparam logic [6:0] SCR_LAST_ROW = 7'(SCR_H - 1);
    localparam logic [6:0] SPR_LAST_ROW = 7'(SPR_H - 1);
    state_t state;
    logic isSprite, blackLat, lastCol, lastPix, onScreen;
    logic [7:0] baseX, col, pixCol;
    logic [6:0] baseY, row, pixRow;
    logic [8:0] sumX;
    logic [7:0] sumY;
    // Coordinates of the pixel to present next cycle; clipping uses the unwrapped wide sums
    always_comb begin
        lastCol  = col == (isSprite ? SPR_LAST_COL : SCR_LAST_COL);
        lastPix  = lastCol && row == (isSprite ? SPR_LAST_ROW : SCR_LAST_ROW);
        pixCol   = state == DRAW ? (lastCol ? 8'd0 : col + 8'd1) : col;
        pixRow   = state == DRAW && lastCol ? row + 7'd1 : row;
        sumX     = {1'b0, baseX} + {1'b0, pixCol};
        sumY     = {1'b0, baseY} + {1'b0, pixRow};
        onScreen = sumX < 9'(SCR_W) && sumY < 8'(SCR_H);
    end
    // Draw sequencer; every output is registered so the pixel bus is glitch-free
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            isSprite   <= 1'b0;
            blackLat   <= 1'b0;
            baseX      <= '0;
            baseY      <= '0;
            col        <= '0;
            row        <= '0;
            screenAck  <= 1'b0;
            spriteAck  <= 1'b0;
            screenDone <= 1'b0;
            spriteDone <= 1'b0;
            x          <= '0;
            y          <= '0;
            romAddr    <= '0;
            memorySel  <= '0;
            black      <= 1'b0;
            plot       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            screenAck  <= 1'b0;
            spriteAck  <= 1'b0;
            screenDone <= 1'b0;
            spriteDone <= 1'b0;
            case (state)
                IDLE: if (screenReq || spriteReq) begin
                    state     <= LATCH;
                    busy      <= 1'b1;
                    isSprite  <= !screenReq;
                    memorySel <= screenReq ? screenSel : spriteSel;
                    blackLat  <= screenReq && screenBlack;
                    baseX     <= screenReq ? 8'd0 : spriteX;
                    baseY     <= screenReq ? 7'd0 : spriteY;
                    col       <= '0;
                    row       <= '0;
                    screenAck <= screenReq;
                    spriteAck <= !screenReq;
                end
                LATCH, DRAW: if (state == DRAW && lastPix) begin
                    state      <= DONE;
                    plot       <= 1'b0;
                    black      <= 1'b0;
                    x          <= '0;
                    y          <= '0;
                    romAddr    <= '0;
                    screenDone <= !isSprite;
                    spriteDone <= isSprite;
                end else begin
                    state   <= DRAW;
                    col     <= pixCol;
                    row     <= pixRow;
                    x       <= sumX[7:0];
                    y       <= sumY[6:0];
                    plot    <= onScreen;
                    black   <= blackLat;
                    romAddr <= state == LATCH ? '0 : romAddr + ADDR_W'(1);
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    memorySel <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: scoreboard bench for draw_scheduler
module tb_draw_scheduler;
    logic clk = 0, resetn = 0, screenReq = 0, screenBlack = 0, spriteReq = 0;
    logic [4:0] screenSel = 0, spriteSel = 0;
    logic [7:0] spriteX = 0;
    logic [6:0] spriteY = 0;
    logic screenAck, spriteAck, screenDone, spriteDone, black, plot, busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [14:0] romAddr;
    logic [4:0] memorySel;

    typedef struct packed {
        logic [7:0]  px;
        logic [6:0]  py;
        logic [14:0] pa;
        logic [4:0]  ps;
        logic        pb;
    } pix_t;
    pix_t expQ[$];
    int passed = 0, total = 0, plotCount = 0, cyc = 0;

    draw_scheduler dut (
        .clk(clk), .resetn(resetn),
        .screenReq(screenReq), .screenSel(screenSel), .screenBlack(screenBlack),
        .spriteReq(spriteReq), .spriteSel(spriteSel), .spriteX(spriteX), .spriteY(spriteY),
        .screenAck(screenAck), .spriteAck(spriteAck), .screenDone(screenDone), .spriteDone(spriteDone),
        .x(x), .y(y), .romAddr(romAddr), .memorySel(memorySel), .black(black), .plot(plot), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: every plotted pixel must match the head of the expected queue
    always @(negedge clk) begin
        if (plot) begin
            pix_t e;
            plotCount++;
            total++;
            if (expQ.size() == 0)
                $display("FAIL pixel: unexpected plot x=%0d y=%0d addr=%0d, required no plot", x, y, romAddr);
            else begin
                e = expQ.pop_front();
                if ({x, y, romAddr, memorySel, black} !== e)
                    $display("FAIL pixel: got x=%0d y=%0d addr=%0d sel=%0d blk=%0d, required x=%0d y=%0d addr=%0d sel=%0d blk=%0d",
                             x, y, romAddr, memorySel, black, e.px, e.py, e.pa, e.ps, e.pb);
                else passed++;
            end
        end
    end

    // Reference model: on-screen pixels of a draw in raster order
    task automatic push_exp(input logic spr, input logic [4:0] sel, input logic blk, input int ox, input int oy);
        int w = spr ? 40 : 160;
        int h = spr ? 40 : 120;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                if (ox + c < 160 && oy + r < 120) begin
                    pix_t p;
                    p.px = 8'(ox + c);
                    p.py = 7'(oy + r);
                    p.pa = 15'(r * w + c);
                    p.ps = sel;
                    p.pb = spr ? 1'b0 : blk;
                    expQ.push_back(p);
                end
    endtask

    task automatic test_reset();
        resetn = 0; screenReq = 1; spriteReq = 1; screenSel = 3;
        repeat (3) @(negedge clk);
        total++;
        if ({screenAck, spriteAck, screenDone, spriteDone, x, y, romAddr, memorySel, black, plot} !== '0)
            $display("FAIL reset_outputs: got %h, required 0",
                     {screenAck, spriteAck, screenDone, spriteDone, x, y, romAddr, memorySel, black, plot});
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
        resetn = 1;
        @(negedge clk);
        total++;
        if ({screenAck, spriteAck} !== 2'b10)
            $display("FAIL reset_release_ack: got screenAck=%b spriteAck=%b, required 1 0", screenAck, spriteAck);
        else passed++;
        resetn = 0; screenReq = 0; spriteReq = 0;
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
    endtask

    task automatic run_draw(input logic spr, input logic [4:0] sel, input logic blk,
                            input int ox, input int oy, input int expPlots);
        int ackCyc;
        bit seen;
        expQ.delete();
        plotCount = 0;
        push_exp(spr, sel, blk, ox, oy);
        if (spr) begin spriteSel = sel; spriteX = 8'(ox); spriteY = 7'(oy); spriteReq = 1; end
        else begin screenSel = sel; screenBlack = blk; screenReq = 1; end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (spr ? spriteAck : screenAck) begin seen = 1; break; end
        end
        total++;
        if (!seen) $display("FAIL ack_timeout: got no ack, required ack within 5 cycles"); else passed++;
        ackCyc = cyc;
        screenReq = 0; spriteReq = 0; screenSel = ~sel; spriteSel = ~sel; spriteX = 0; spriteY = 0;
        seen = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (spr ? spriteDone : screenDone) begin seen = 1; break; end
        end
        total++;
        if (!seen) $display("FAIL done_timeout: got no done, required done"); else passed++;
        total++;
        if (cyc - ackCyc !== (spr ? 1601 : 19201))
            $display("FAIL ack_to_done: got %0d cycles, required %0d", cyc - ackCyc, spr ? 1601 : 19201);
        else passed++;
        total++;
        if (plotCount !== expPlots) $display("FAIL plot_count: got %0d, required %0d", plotCount, expPlots);
        else passed++;
        total++;
        if (expQ.size() !== 0) $display("FAIL missing_pixels: got %0d left, required 0", expQ.size()); else passed++;
        @(negedge clk);
        total++;
        if ({busy, memorySel, screenDone, spriteDone, plot} !== '0)
            $display("FAIL back_to_idle: got busy=%b sel=%0d sdone=%b pdone=%b plot=%b, required all 0",
                     busy, memorySel, screenDone, spriteDone, plot);
        else passed++;
    endtask

    task automatic test_screen();
        run_draw(1'b0, 5'd3, 1'b0, 0, 0, 19200);
    endtask

    task automatic test_sprite();
        run_draw(1'b1, 5'd7, 1'b0, 10, 20, 1600);
    endtask

    task automatic test_clip();
        run_draw(1'b1, 5'd2, 1'b0, 140, 100, 400);
    endtask

    task automatic test_priority();
        int doneCyc, lateAcks;
        bit seen;
        expQ.delete();
        push_exp(1'b0, 5'd1, 1'b1, 0, 0);
        screenSel = 1; screenBlack = 1; spriteSel = 4; spriteX = 100; spriteY = 90;
        screenReq = 1; spriteReq = 1;
        @(negedge clk);
        total++;
        if ({screenAck, spriteAck} !== 2'b10)
            $display("FAIL priority_ack: got screenAck=%b spriteAck=%b, required 1 0", screenAck, spriteAck);
        else passed++;
        screenReq = 0;
        seen = 0; lateAcks = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (spriteAck) lateAcks++;
            if (screenDone) begin seen = 1; break; end
        end
        total++;
        if (!seen || lateAcks !== 0)
            $display("FAIL priority_screen: got done=%b spriteAcks=%0d, required done=1 spriteAcks=0", seen, lateAcks);
        else passed++;
        doneCyc = cyc;
        push_exp(1'b1, 5'd4, 1'b0, 100, 90);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (spriteAck) begin seen = 1; break; end
        end
        total++;
        if (!seen || cyc - doneCyc !== 2)
            $display("FAIL pending_sprite_ack: got %0d cycles after screenDone, required 2", seen ? cyc - doneCyc : -1);
        else passed++;
        spriteReq = 0;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (spriteDone) begin seen = 1; break; end
        end
        total++;
        if (!seen || expQ.size() !== 0)
            $display("FAIL pending_sprite_draw: got done=%b left=%0d, required done=1 left=0", seen, expQ.size());
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        expQ.delete();
        push_exp(1'b0, 5'd5, 1'b0, 0, 0);
        screenSel = 5; screenBlack = 0; screenReq = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (screenAck) begin seen = 1; break; end
        end
        total++;
        if (!seen) $display("FAIL midreset_ack: got no ack, required ack"); else passed++;
        screenReq = 0;
        n = 0;
        for (int i = 0; i < 1000 && n < 500; i++) begin
            @(negedge clk);
            if (plot) n++;
        end
        resetn = 0;
        #1;
        total++;
        if ({plot, busy} !== 2'b00) $display("FAIL midreset_now: got plot=%b busy=%b, required 0 0", plot, busy);
        else passed++;
        total++;
        if ({x, y, romAddr, memorySel} !== '0)
            $display("FAIL midreset_bus: got x=%0d y=%0d addr=%0d sel=%0d, required 0", x, y, romAddr, memorySel);
        else passed++;
        repeat (2) @(negedge clk);
        expQ.delete();
        resetn = 1;
        seen = 0;
        repeat (19300) begin
            @(negedge clk);
            if (screenDone || busy) seen = 1;
        end
        total++;
        if (seen) $display("FAIL midreset_no_done: got done/busy after reset, required none"); else passed++;
    endtask

    initial begin
        test_reset();
        test_screen();
        test_sprite();
        test_clip();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
